// File: rtl/sobel_magnitude.sv
`default_nettype none
// ============================================================================
// Module   : sobel_magnitude
// Purpose  : Streaming 3x3 Sobel edge detector for a raster-order 8-bit
//            grayscale frame. Two line buffers plus a 3x3 window produce one
//            edge magnitude per input pixel; borders are forced to 0.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            pix_i, valid_i    - input pixel stream (accepted when !busy_o)
//            busy_o            - high while the last line is flushed out
//            grayscale_o       - edge magnitude, valid with done_o
//            done_o            - 1-cycle strobe per output pixel
//            frame_done_o      - 1-cycle strobe with the frame's last done_o
// Config   : `define SOBEL_THRESHOLD_EN to binarise the magnitude against
//            THRESHOLD (255 when mag >= THRESHOLD, else 0).
// Revision : 1.0 - initial release
// ============================================================================
module sobel_magnitude #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int THRESHOLD  = 128
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pix_i,
   input  logic       valid_i,
   output logic       busy_o,
   output logic [7:0] grayscale_o,
   output logic       done_o,
   output logic       frame_done_o
);

   localparam int c_col_w = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int c_row_w = $clog2(IMG_HEIGHT + 2);

   localparam logic [c_col_w-1:0] c_last_col = c_col_w'(IMG_WIDTH - 1);
   localparam logic [c_col_w-1:0] c_one_col  = c_col_w'(1);
   localparam logic [c_row_w-1:0] c_one_row  = c_row_w'(1);
   localparam logic [c_row_w-1:0] c_last_row = c_row_w'(IMG_HEIGHT - 1);
   localparam logic [c_row_w-1:0] c_img_rows = c_row_w'(IMG_HEIGHT);
   localparam logic [c_row_w-1:0] c_end_row  = c_row_w'(IMG_HEIGHT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_RUN   = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t r_state, w_state_nxt;

   // Position of the pixel entering the window. During FLUSH the row
   // counter runs past the image (rows H and H+1) for the pseudo-pixels.
   logic [c_col_w-1:0] r_col;
   logic [c_row_w-1:0] r_row;

   logic [7:0] r_lb_top [IMG_WIDTH];   // line r-2 relative to the input row
   logic [7:0] r_lb_mid [IMG_WIDTH];   // line r-1
   logic [7:0] r_win    [3][3];        // [row: top..bottom][col: left..right]

   logic       r_win_vld;
   logic       r_win_border;
   logic       r_win_last;

   logic       w_step;
   logic       w_emit;
   logic       w_fill_end;
   logic       w_last_in;
   logic       w_flush_end;
   logic       w_border;
   logic [7:0] w_top, w_mid, w_bot;

   assign busy_o      = (r_state == S_FLUSH);
   assign w_step      = busy_o | valid_i;
   assign w_emit      = w_step & ((r_state == S_RUN) | (r_state == S_FLUSH));
   assign w_fill_end  = (r_row == c_one_row) && (r_col == '0);
   assign w_last_in   = (r_row == c_last_row) && (r_col == c_last_col);
   assign w_flush_end = (r_row == c_end_row);

   assign w_top = r_lb_top[r_col];
   assign w_mid = r_lb_mid[r_col];
   assign w_bot = busy_o ? 8'd0 : pix_i;

   // The window centre sits one row up and one column left of the input.
   // Input column 0 puts the centre at the previous line's last column, and
   // input column 1 puts it at column 0: both are borders, so the window
   // content that wrapped across lines is never used.
   assign w_border = (r_col <= c_one_col) || (r_row == c_one_row) ||
                     (r_row == c_img_rows);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_step)              w_state_nxt = S_FILL;
         S_FILL:  if (w_step && w_fill_end) w_state_nxt = S_RUN;
         S_RUN:   if (w_step && w_last_in)  w_state_nxt = S_FLUSH;
         S_FLUSH: if (w_flush_end)          w_state_nxt = S_IDLE;
         default:                           w_state_nxt = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------- counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_step) begin
         if (busy_o && w_flush_end) begin
            r_col <= '0;
            r_row <= '0;
         end else if (r_col == c_last_col) begin
            r_col <= '0;
            r_row <= r_row + c_one_row;
         end else begin
            r_col <= r_col + c_one_col;
         end
      end
   end

   // ------------------------------------------------ line buffers, window
   always_ff @(posedge clk) begin
      if (w_step) begin
         r_lb_top[r_col] <= w_mid;
         r_lb_mid[r_col] <= w_bot;
         for (int i = 0; i < 3; i++) begin
            r_win[i][0] <= r_win[i][1];
            r_win[i][1] <= r_win[i][2];
         end
         r_win[0][2] <= w_top;
         r_win[1][2] <= w_mid;
         r_win[2][2] <= w_bot;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_win_vld    <= 1'b0;
         r_win_border <= 1'b0;
         r_win_last   <= 1'b0;
      end else begin
         r_win_vld <= w_emit;
         if (w_step) begin
            r_win_border <= w_border;
            r_win_last   <= busy_o & w_flush_end;
         end
      end
   end

   // ------------------------------------------------------ Sobel datapath
   logic        [10:0] w_xr, w_xl, w_yb, w_yt;
   logic signed [10:0] w_gx, w_gy;
   logic        [10:0] w_ax, w_ay, w_mag;
   logic        [7:0]  w_level;

   always_comb begin
      w_xr = {3'b000, r_win[0][2]} + {2'b00, r_win[1][2], 1'b0} + {3'b000, r_win[2][2]};
      w_xl = {3'b000, r_win[0][0]} + {2'b00, r_win[1][0], 1'b0} + {3'b000, r_win[2][0]};
      w_yb = {3'b000, r_win[2][0]} + {2'b00, r_win[2][1], 1'b0} + {3'b000, r_win[2][2]};
      w_yt = {3'b000, r_win[0][0]} + {2'b00, r_win[0][1], 1'b0} + {3'b000, r_win[0][2]};
      // Each sum is at most 1020, so the 11-bit difference cannot overflow.
      w_gx  = $signed(w_xr - w_xl);
      w_gy  = $signed(w_yb - w_yt);
      w_ax  = w_gx[10] ? 11'(-w_gx) : w_gx;
      w_ay  = w_gy[10] ? 11'(-w_gy) : w_gy;
      w_mag = w_ax + w_ay;
`ifdef SOBEL_THRESHOLD_EN
      w_level = (w_mag >= 11'(THRESHOLD)) ? 8'hFF : 8'h00;
`else
      w_level = (w_mag > 11'd255) ? 8'hFF : w_mag[7:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grayscale_o  <= 8'd0;
         done_o       <= 1'b0;
         frame_done_o <= 1'b0;
      end else begin
         done_o       <= r_win_vld;
         frame_done_o <= r_win_vld & r_win_last;
         if (r_win_vld)
            grayscale_o <= r_win_border ? 8'd0 : w_level;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sobel_magnitude.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_magnitude
// Purpose  : Directed self-checking bench for sobel_magnitude on a 4x4 frame.
//            Honours SOBEL_THRESHOLD_EN (THRESHOLD=100) for expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_magnitude;

   localparam int W = 4;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pix_i;
   logic       valid_i;
   logic       busy_o;
   logic [7:0] grayscale_o;
   logic       done_o;
   logic       frame_done_o;

   int n_vec   = 0;
   int n_err   = 0;
   int n_stray = 0;
   int cyc     = 0;
   int acc5    = 0;

   typedef struct packed {
      logic [7:0]  val;
      logic        fd;
      logic [31:0] cyc;
   } out_t;

   out_t q [$];

   sobel_magnitude #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .THRESHOLD  (100)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pix_i        (pix_i),
      .valid_i      (valid_i),
      .busy_o       (busy_o),
      .grayscale_o  (grayscale_o),
      .done_o       (done_o),
      .frame_done_o (frame_done_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst === 1'b0 && done_o === 1'b1)
         q.push_back('{grayscale_o, frame_done_o, 32'(cyc)});
      if (rst === 1'b0 && frame_done_o === 1'b1 && done_o !== 1'b1)
         n_stray++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // 0: flat 100, 1: vertical edge, 2: ramp col*10, 3: ramp col*30
   function automatic logic [7:0] pix_of(input int mode, input int c);
      case (mode)
         0:       return 8'd100;
         1:       return (c < 2) ? 8'd0 : 8'd255;
         2:       return 8'(c * 10);
         default: return 8'(c * 30);
      endcase
   endfunction

   // Hand-derived: edge 4*255=1020, ramp10 4*20=80, ramp30 4*60=240.
   function automatic logic [7:0] exp_of(input int mode, input int r, input int c);
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
`ifdef SOBEL_THRESHOLD_EN
      case (mode)
         0:       return 8'd0;
         1:       return 8'd255;
         2:       return 8'd0;
         default: return 8'd255;
      endcase
`else
      case (mode)
         0:       return 8'd0;
         1:       return 8'd255;
         2:       return 8'd80;
         default: return 8'd240;
      endcase
`endif
   endfunction

   task automatic drive_pixels(input int mode, input int count, input bit gap);
      for (int idx = 0; idx < count; idx++) begin
         @(negedge clk);
         if (gap) begin
            valid_i = 1'b0;
            pix_i   = 8'hA5;
            @(negedge clk);
         end
         pix_i   = pix_of(mode, idx % W);
         valid_i = 1'b1;
         if (idx == W + 1) acc5 = cyc;
      end
      @(negedge clk);
      valid_i = 1'b0;
      pix_i   = 8'h00;
   endtask

   task automatic run_frame(input int mode, input bit gap, input string tag);
      q.delete();
      n_stray = 0;
      drive_pixels(mode, W * H, gap);
      check({tag, "_busy_flush"}, 32'(busy_o), 32'd1);
      for (int i = 0; i < 200 && q.size() < W * H; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      check({tag, "_count"}, q.size(), W * H);
      check({tag, "_stray_fd"}, n_stray, 0);
      check({tag, "_busy_idle"}, 32'(busy_o), 32'd0);
      for (int k = 0; k < q.size() && k < W * H; k++) begin
         check($sformatf("%s_val_k%0d", tag, k), 32'(q[k].val), 32'(exp_of(mode, k / W, k % W)));
         check($sformatf("%s_fd_k%0d", tag, k), 32'(q[k].fd), (k == W * H - 1) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      // Reset held 3 cycles while a pixel is offered
      rst     = 1'b1;
      valid_i = 1'b1;
      pix_i   = 8'hFF;
      repeat (3) begin
         @(negedge clk);
         check("rst_gray", 32'(grayscale_o), 32'd0);
         check("rst_done", 32'(done_o), 32'd0);
         check("rst_fdone", 32'(frame_done_o), 32'd0);
         check("rst_busy", 32'(busy_o), 32'd0);
      end
      rst     = 1'b0;
      valid_i = 1'b0;
      pix_i   = 8'h00;
      repeat (4) @(negedge clk);
      check("idle_no_output", q.size(), 0);

      // Flat frame, plus first-output latency
      run_frame(0, 1'b0, "flat");
      if (q.size() > 0)
         check("latency_first", q[0].cyc - 32'(acc5), 32'd2);
      else
         check("latency_first", 32'd0, 32'd1);

      run_frame(1, 1'b0, "edge");
      run_frame(2, 1'b0, "ramp10");
      run_frame(2, 1'b1, "ramp10_gap");

      // Reset after the 9th accepted pixel abandons the frame
      drive_pixels(1, 9, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      q.delete();
      repeat (5) @(negedge clk);
      check("midrst_no_stale", q.size(), 0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      run_frame(1, 1'b0, "edge_after_rst");

      run_frame(3, 1'b0, "ramp30");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
